reaction_measure_state: RTL and testbench
=========================================

# reaction_measure_state

Sub-state responder for the reaction-timer top-level sequencer's timing phase (sequencer state 2). While `enable` is high, the block:
- arms after KEY[0] is released;
- waits a pseudo-random delay, then lights the LEDs;
- counts elapsed milliseconds in 4-digit BCD until KEY[0] is pressed.

It returns the measured score digits and requests sequencer state 3 through `out_state`. It drives LEDR/HEX0–3, which the sequencer muxes through only while in state 2.

## Interface
- CLK_HZ, 50_000_000, clock frequency; TICK_DIV = CLK_HZ/1000 cycles per ms tick
- MIN_DELAY_MS, 1000, minimum arm-to-light delay
- RAND_BITS, 11, LFSR bits added to the delay (0..2^RAND_BITS−1 ms)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared
- enable  in  1  high while the sequencer is in state 2
- KEY  in  2  push-buttons, active-low; KEY[0] is the reaction key, KEY[1] is unused
- SW  in  10  SW[9]=1 forces a fixed delay of MIN_DELAY_MS; other bits unused
- LEDR  out  10  stimulus/result LEDs
- HEX0..HEX3  out  8 each  active-low 7-segment, bit 7 = DP; 8'hff = blank; HEX0 = ms units
- score_a..score_d  out  4 each  BCD score; score_a = thousands, score_d = units
- out_state  out  4  requested sequencer state: 4'd2 = stay, 4'd3 = go to score display

## Operation
- KEY[0] passes through a 2-FF synchronizer. A press is a registered 1→0 edge of the synchronized level.
- 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, free-running every cycle.

FSM states: IDLE, RELEASE, DELAY, RUN, DONE.
- IDLE: enable=1 → RELEASE.
- RELEASE: waits for synchronized KEY[0]=1 (key released), then → DELAY.
  - On entry to DELAY, load the delay counter with MIN_DELAY_MS + LFSR[RAND_BITS-1:0], or MIN_DELAY_MS if SW[9]=1.
  - Clear the BCD counter.
- DELAY: decrement once per ms tick; reaching 0 → RUN.
  - A press in DELAY is a false start: score = 9999, false-start flag set, → DONE.
- RUN: BCD counter increments per tick; digits wrap 9→0 with carry.
  - Press → freeze count, latch score, → DONE.
  - Count reaching 9999 saturates and → DONE with score 9999, flag clear.
- DONE: holds score and outputs until enable=0.
- enable=0 in any state → IDLE on the next edge. The tick prescaler and BCD counter clear; score_* is held; display blanks.
- Outputs by state:
  - IDLE/RELEASE/DELAY: LEDR=0, HEX blank.
  - RUN: LEDR=10'h3ff, HEX shows the live count.
  - DONE: HEX shows the score. LEDR=10'h001 on a valid result, 10'h200 on a false start.
- out_state = 4'd3 only in DONE; 4'd2 otherwise.
- Reset values: LEDR=0, HEX0..3=8'hff, score_*=0, out_state=4'd2, FSM=IDLE.

## Timing
- All outputs are registered.
- score_* and out_state=3 become valid on the same edge.
- Raw KEY[0] falling edge → DONE: 3 clk (2 sync + 1 edge detect). The count value frozen is the value present on that edge.
- The ms prescaler restarts at 0 on entry to DELAY and again on entry to RUN. The first RUN increment occurs TICK_DIV cycles after RUN entry.
- A press and a tick on the same cycle: the press wins and the count does not increment.
- A press on the same cycle as the DELAY→RUN transition counts as a false start.
- enable falling mid-DELAY/RUN aborts; no score update.
- Async reset mid-operation returns all outputs to their reset values immediately.

## Structure
- Shared package holds:
  - sequencer state codes (ST_DEFAULT=0, ST_WAIT=1, ST_TIMING=2, ST_SCORE=3, ST_HIGH=4);
  - the blank constant 8'hff;
  - the false-start score 9999.
- Sub-module `bcd_ms_counter`: 4-digit BCD counter with clear, increment, saturate-at-9999 flag.
- Segment encoding reuses the existing `bcd_decoder`.

## Test plan
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=3, SW[9]=1.
- Reset asserted mid-RUN → LEDR=0, HEX*=8'hff, score=0, out_state=2 asynchronously.
- enable with KEY[0] held low for 20 clk, then release → stays in RELEASE (LEDR=0). DELAY begins after release; RUN (LEDR=3ff) 12 clk later.
- Press 27 clk after RUN entry → out_state=3, score=0006 (27 clk = 6 full 4-cycle ticks before the press registers 3 clk later), LEDR=10'h001, HEX3..0 show 0,0,0,6.
- Press during DELAY → score=9999, LEDR=10'h200, out_state=3 three clk after the press.
- No press → count passes 0009→0010 and 0099→0100 correctly; saturates at 9999, out_state=3, LEDR=10'h001.
- Drop enable in DONE → IDLE next clk, out_state=2, HEX blank, score held. Re-enable starts a fresh measurement with the count restarting at 0000.

Source files
------------

// File: rtl/reaction_measure_state_pkg.sv
// Shared constants and helpers for the reaction-timer sequencer and its
// timing-phase responder.
package reaction_measure_state_pkg;

  typedef logic [15:0] bcd4_t;
  typedef logic [7:0]  seg_t;

  localparam logic [3:0] ST_DEFAULT = 4'd0;
  localparam logic [3:0] ST_WAIT    = 4'd1;
  localparam logic [3:0] ST_TIMING  = 4'd2;
  localparam logic [3:0] ST_SCORE   = 4'd3;
  localparam logic [3:0] ST_HIGH    = 4'd4;

  localparam seg_t  HEX_BLANK         = 8'hff;
  localparam bcd4_t BCD_ZERO          = 16'h0000;
  localparam bcd4_t BCD_MAX           = 16'h9999;
  localparam bcd4_t SCORE_FALSE_START = 16'h9999;
  localparam logic [15:0] LFSR_SEED   = 16'hace1;

  // Four-digit BCD increment; 9999 wraps to 0000 (callers saturate).
  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_measure_state_if.sv
// Sequencer-facing signal bundle of the timing-phase responder.
interface reaction_measure_state_if;
  logic       enable;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [7:0] HEX0;
  logic [7:0] HEX1;
  logic [7:0] HEX2;
  logic [7:0] HEX3;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [3:0] score_c;
  logic [3:0] score_d;
  logic [3:0] out_state;

  modport master (
    output enable, KEY, SW,
    input  LEDR, HEX0, HEX1, HEX2, HEX3,
    input  score_a, score_b, score_c, score_d, out_state
  );

  modport slave (
    input  enable, KEY, SW,
    output LEDR, HEX0, HEX1, HEX2, HEX3,
    output score_a, score_b, score_c, score_d, out_state
  );
endinterface

// File: rtl/bcd_decoder.sv
// BCD digit to active-low 7-segment pattern, decimal point off; non-BCD blanks.
module bcd_decoder (
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 8'hc0;
      4'd1:    seg_o = 8'hf9;
      4'd2:    seg_o = 8'ha4;
      4'd3:    seg_o = 8'hb0;
      4'd4:    seg_o = 8'h99;
      4'd5:    seg_o = 8'h92;
      4'd6:    seg_o = 8'h82;
      4'd7:    seg_o = 8'hf8;
      4'd8:    seg_o = 8'h80;
      4'd9:    seg_o = 8'h90;
      default: seg_o = 8'hff;
    endcase
  end

endmodule

// File: rtl/reaction_measure_state_bcd_ms_counter.sv
// Four-digit BCD millisecond counter with clear, increment and saturation at 9999.
module bcd_ms_counter
  import reaction_measure_state_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr_i,
  input  logic  inc_i,
  output bcd4_t count_o,
  output bcd4_t count_next_o,
  output logic  sat_o
);

  bcd4_t count_q;
  bcd4_t count_d;

  always_comb begin
    if (clr_i) begin
      count_d = BCD_ZERO;
    end else if (inc_i && (count_q != BCD_MAX)) begin
      count_d = bcd_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= BCD_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  // Derived from the current value, not count_d, so the FSM can use it without a loop through clr_i.
  assign sat_o = inc_i && (count_q != BCD_MAX) && (bcd_inc(count_q) == BCD_MAX);

endmodule

// File: rtl/reaction_measure_state.sv
// Timing-phase responder: arm on key release, random delay, light LEDs,
// then measure the reaction in BCD milliseconds until KEY[0] is pressed.
module reaction_measure_state
  import reaction_measure_state_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  reaction_measure_state_if.slave bus
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TICK_W   = $clog2(TICK_DIV + 1);
  localparam int DLY_W    = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RELEASE = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic              key_s1_q, key_s1_d;
  logic              key_s2_q, key_s2_d;
  logic              key_prev_q, key_prev_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  bcd4_t             score_q, score_d;
  logic              false_start_q, false_start_d;
  logic [9:0]        ledr_q, ledr_d;
  seg_t [3:0]        hex_q, hex_d;
  logic [3:0]        out_state_q, out_state_d;

  logic       press_s;
  logic       tick_s;
  logic       cnt_clr_s;
  logic       cnt_inc_s;
  logic       cnt_sat_s;
  bcd4_t      count_s;
  bcd4_t      count_next_s;
  bcd4_t      digits_s;
  seg_t [3:0] seg_s;
  logic       unused_s;

  assign unused_s = ^{bus.KEY[1], bus.SW[8:0]};

  always_comb begin
    key_s1_d   = bus.KEY[0];
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign press_s = key_prev_q & ~key_s2_q;
  assign tick_s  = ((state_q == S_DELAY) || (state_q == S_RUN)) &&
                   (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  // Press is checked ahead of the tick, so a simultaneous press wins in both DELAY and RUN.
  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    score_d       = score_q;
    false_start_d = false_start_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RELEASE;
        S_RELEASE: begin
          if (key_s2_q) begin
            state_d = S_DELAY;
            delay_d = bus.SW[9] ? DLY_W'(MIN_DELAY_MS)
                                : DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
          end else begin
            state_d = S_RELEASE;
          end
        end
        S_DELAY: begin
          if (press_s) begin
            state_d       = S_DONE;
            score_d       = SCORE_FALSE_START;
            false_start_d = 1'b1;
          end else if (tick_s) begin
            delay_d = delay_q - DLY_W'(1);
            if (delay_q <= DLY_W'(1)) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DELAY;
            end
          end else begin
            state_d = S_DELAY;
          end
        end
        S_RUN: begin
          if (press_s) begin
            state_d       = S_DONE;
            score_d       = count_s;
            false_start_d = 1'b0;
          end else if (cnt_sat_s) begin
            state_d       = S_DONE;
            score_d       = BCD_MAX;
            false_start_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The prescaler only runs inside a phase; any state change restarts it at zero.
  always_comb begin
    if (((state_q == S_DELAY) || (state_q == S_RUN)) && (state_d == state_q) && !tick_s) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end else begin
      tick_cnt_d = TICK_W'(0);
    end
  end

  assign cnt_clr_s = (state_d == S_IDLE) || ((state_d == S_DELAY) && (state_q != S_DELAY));
  assign cnt_inc_s = (state_q == S_RUN) && tick_s && !press_s;

  bcd_ms_counter u_counter (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (cnt_clr_s),
    .inc_i        (cnt_inc_s),
    .count_o      (count_s),
    .count_next_o (count_next_s),
    .sat_o        (cnt_sat_s)
  );

  assign digits_s = (state_d == S_RUN) ? count_next_s : score_d;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_decoder u_dec (
      .bcd_i (digits_s[g*4 +: 4]),
      .seg_o (seg_s[g])
    );
  end

  // Outputs are computed from next-state values so they change on the same edge as the FSM.
  always_comb begin
    ledr_d      = 10'h000;
    out_state_d = ST_TIMING;
    case (state_d)
      S_RUN: ledr_d = 10'h3ff;
      S_DONE: begin
        ledr_d      = false_start_d ? 10'h200 : 10'h001;
        out_state_d = ST_SCORE;
      end
      default: ledr_d = 10'h000;
    endcase
    for (int i = 0; i < 4; i++) begin
      if ((state_d == S_RUN) || (state_d == S_DONE)) begin
        hex_d[i] = seg_s[i];
      end else begin
        hex_d[i] = HEX_BLANK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      key_prev_q    <= 1'b1;
      lfsr_q        <= LFSR_SEED;
      state_q       <= S_IDLE;
      tick_cnt_q    <= TICK_W'(0);
      delay_q       <= DLY_W'(0);
      score_q       <= BCD_ZERO;
      false_start_q <= 1'b0;
      ledr_q        <= 10'h000;
      hex_q         <= {4{HEX_BLANK}};
      out_state_q   <= ST_TIMING;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      key_prev_q    <= key_prev_d;
      lfsr_q        <= lfsr_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      delay_q       <= delay_d;
      score_q       <= score_d;
      false_start_q <= false_start_d;
      ledr_q        <= ledr_d;
      hex_q         <= hex_d;
      out_state_q   <= out_state_d;
    end
  end

  assign bus.LEDR      = ledr_q;
  assign bus.HEX0      = hex_q[0];
  assign bus.HEX1      = hex_q[1];
  assign bus.HEX2      = hex_q[2];
  assign bus.HEX3      = hex_q[3];
  assign bus.score_a   = score_q[15:12];
  assign bus.score_b   = score_q[11:8];
  assign bus.score_c   = score_q[7:4];
  assign bus.score_d   = score_q[3:0];
  assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_reaction_measure_state.sv
// Directed bench for reaction_measure_state: 1 ms = 4 clk, 3 ms fixed delay (SW[9]=1).
module tb_reaction_measure_state;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  reaction_measure_state_if bus ();

  reaction_measure_state #(
    .CLK_HZ       (4000),
    .MIN_DELAY_MS (3),
    .RAND_BITS    (11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] ledr, input logic [3:0] os,
                           input logic [15:0] score, input logic [31:0] hex);
    chk({tag, "/ledr"}, {22'd0, bus.LEDR}, {22'd0, ledr});
    chk({tag, "/out_state"}, {28'd0, bus.out_state}, {28'd0, os});
    chk({tag, "/score"}, {16'd0, bus.score_a, bus.score_b, bus.score_c, bus.score_d},
        {16'd0, score});
    chk({tag, "/hex"}, {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, hex);
  endtask

  // Drop enable with the key released long enough to pass the synchronizer, then re-enable.
  task automatic rearm();
    bus.KEY    = 2'b11;
    bus.enable = 1'b0;
    cyc(3);
    bus.enable = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.KEY     = 2'b11;
    bus.SW      = 10'h200;
    cyc(3);
    reset = 1'b0;
    check_all("reset", 10'h000, 4'd2, 16'h0000, 32'hffffffff);

    // Key held down while arming: must stay in RELEASE.
    bus.KEY = 2'b10;
    cyc(3);
    bus.enable = 1'b1;
    cyc(21);
    check_all("held_key", 10'h000, 4'd2, 16'h0000, 32'hffffffff);
    bus.KEY = 2'b11;
    cyc(14);
    check_all("delay_end", 10'h000, 4'd2, 16'h0000, 32'hffffffff);
    cyc(1);
    check_all("run_entry", 10'h3ff, 4'd2, 16'h0000, 32'hc0c0c0c0);
    cyc(4);
    check_all("run_1ms", 10'h3ff, 4'd2, 16'h0000, 32'hc0c0c0f9);
    cyc(20);
    check_all("run_6ms", 10'h3ff, 4'd2, 16'h0000, 32'hc0c0c082);
    // Key falls here; DONE is registered 3 clk later, 27 clk after RUN entry.
    bus.KEY = 2'b10;
    cyc(2);
    check_all("press_sync", 10'h3ff, 4'd2, 16'h0000, 32'hc0c0c082);
    cyc(1);
    check_all("press_done", 10'h001, 4'd3, 16'h0006, 32'hc0c0c082);
    bus.KEY = 2'b11;
    cyc(5);
    check_all("done_hold", 10'h001, 4'd3, 16'h0006, 32'hc0c0c082);

    bus.enable = 1'b0;
    cyc(1);
    check_all("disable", 10'h000, 4'd2, 16'h0006, 32'hffffffff);

    // Press on the same edge as the second tick: count freezes at 1.
    rearm();
    cyc(14);
    check_all("rerun_entry", 10'h3ff, 4'd2, 16'h0006, 32'hc0c0c0c0);
    cyc(5);
    bus.KEY = 2'b10;
    cyc(3);
    check_all("press_on_tick", 10'h001, 4'd3, 16'h0001, 32'hc0c0c0f9);

    // False start during DELAY.
    rearm();
    cyc(4);
    bus.KEY = 2'b10;
    cyc(2);
    check_all("fs_sync", 10'h000, 4'd2, 16'h0001, 32'hffffffff);
    cyc(1);
    check_all("false_start", 10'h200, 4'd3, 16'h9999, 32'h90909090);

    // Press registering on the DELAY->RUN edge is still a false start.
    rearm();
    cyc(11);
    bus.KEY = 2'b10;
    cyc(3);
    check_all("fs_at_run", 10'h200, 4'd3, 16'h9999, 32'h90909090);

    // Abort mid-RUN: score is left alone.
    rearm();
    cyc(24);
    bus.enable = 1'b0;
    cyc(1);
    check_all("abort", 10'h000, 4'd2, 16'h9999, 32'hffffffff);

    // Free run to saturation.
    rearm();
    cyc(14);
    check_all("sat_entry", 10'h3ff, 4'd2, 16'h9999, 32'hc0c0c0c0);
    cyc(36);
    check_all("cnt_0009", 10'h3ff, 4'd2, 16'h9999, 32'hc0c0c090);
    cyc(4);
    check_all("cnt_0010", 10'h3ff, 4'd2, 16'h9999, 32'hc0c0f9c0);
    cyc(356);
    check_all("cnt_0099", 10'h3ff, 4'd2, 16'h9999, 32'hc0c09090);
    cyc(4);
    check_all("cnt_0100", 10'h3ff, 4'd2, 16'h9999, 32'hc0f9c0c0);
    cyc(39595);
    check_all("cnt_9998", 10'h3ff, 4'd2, 16'h9999, 32'h90909080);
    cyc(1);
    check_all("saturate", 10'h001, 4'd3, 16'h9999, 32'h90909090);

    // Asynchronous reset in the middle of a RUN, checked between edges.
    rearm();
    cyc(24);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 10'h000, 4'd2, 16'h0000, 32'hffffffff);
    cyc(2);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
